mole_hit_detector: RTL and testbench

- Upstream stage of the game datapath. Picks a pseudo-random mole hole and lights it for a fixed window.
- Debounces the raw active-low hole pushbuttons and classifies each round as a hit or a miss.
- Drives the datapath's player_signal input with a one-cycle hit pulse, and emits a one-cycle miss pulse.
- Runs only while the control FSM asserts enable (play states).

---
 rtl/mole_hit_detector.sv | 194 +++++++++++++++++++
 tb/tb_mole_hit_detector.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mole_hit_detector.sv
// Mole game front end: lights a pseudo-random hole for a fixed window and classifies
// each round as a hit or a miss from debounced active-low keys.
module mole_hit_detector #(
  parameter int unsigned NUM_HOLES     = 4,
  parameter int unsigned WINDOW_CYCLES = 50000000,
  parameter int unsigned GAP_CYCLES    = 12500000,
  parameter int unsigned DB_CYCLES     = 500000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  localparam int unsigned IDX_W        = $clog2(NUM_HOLES)
) (
  input  logic                 clk,
  input  logic                 Resetn,
  input  logic                 enable,
  input  logic [NUM_HOLES-1:0] key_n,
  output logic [NUM_HOLES-1:0] mole_onehot,
  output logic [IDX_W-1:0]     mole_idx,
  output logic                 mole_up,
  output logic                 player_signal,
  output logic                 miss_signal
);

  localparam int unsigned DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned TIMER_W = 27;

  localparam logic [DB_W-1:0]    DbLast  = DB_W'(DB_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GapLast = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WinLast = TIMER_W'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StGap, StUp} state_e;

  // ---------------------------------------------------------------------------
  // Key input path: synchronizer, per-key stability counter, press edge
  // ---------------------------------------------------------------------------
  logic [NUM_HOLES-1:0] sync1_q, sync2_q;
  logic [NUM_HOLES-1:0] db_q, db_d;
  logic [NUM_HOLES-1:0] press_q, press_d;
  logic [DB_W-1:0]      db_cnt_q [NUM_HOLES];
  logic [DB_W-1:0]      db_cnt_d [NUM_HOLES];

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_HOLES; i++) begin
      db_d[i]     = db_q[i];
      db_cnt_d[i] = '0;
      // Level is accepted only after DB_CYCLES consecutive disagreeing cycles.
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          db_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
    press_d = db_q & ~db_d;
  end

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      db_q    <= '1;
      press_q <= '0;
      for (int i = 0; i < NUM_HOLES; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      db_q    <= db_d;
      press_q <= press_d;
      for (int i = 0; i < NUM_HOLES; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Free-running LFSR (x^16 + x^14 + x^13 + x^11 + 1)
  // ---------------------------------------------------------------------------
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Round FSM
  // ---------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [NUM_HOLES-1:0] mole_onehot_q, mole_onehot_d;
  logic [IDX_W-1:0]     mole_idx_q, mole_idx_d;
  logic                 mole_up_q, mole_up_d;
  logic                 player_q, player_d;
  logic                 miss_q, miss_d;
  logic [IDX_W-1:0]     cand, pick;
  logic                 hit, any_press;

  always_comb begin
    cand = lfsr_q[IDX_W-1:0];
    // Never repeat the previous hole; NUM_HOLES is a power of two so the add wraps.
    pick = (cand == mole_idx_q) ? cand + IDX_W'(1) : cand;
    hit       = |(press_q & mole_onehot_q);
    any_press = |press_q;
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q + TIMER_W'(1);
    mole_onehot_d = mole_onehot_q;
    mole_idx_d    = mole_idx_q;
    mole_up_d     = mole_up_q;
    player_d      = 1'b0;
    miss_d        = 1'b0;

    if (!enable) begin
      // Abandoned round: go dark, keep the last index, no verdict.
      state_d       = StIdle;
      timer_d       = '0;
      mole_onehot_d = '0;
      mole_up_d     = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StGap;
          timer_d = '0;
        end
        StGap: begin
          if (timer_q == GapLast) begin
            state_d       = StUp;
            timer_d       = '0;
            mole_idx_d    = pick;
            mole_onehot_d = NUM_HOLES'(1) << pick;
            mole_up_d     = 1'b1;
          end
        end
        StUp: begin
          if (hit || any_press || timer_q == WinLast) begin
            state_d       = StGap;
            timer_d       = '0;
            mole_onehot_d = '0;
            mole_up_d     = 1'b0;
            player_d      = hit;
            miss_d        = !hit;
          end
        end
        default: begin
          state_d = StIdle;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      mole_onehot_q <= '0;
      mole_idx_q    <= '0;
      mole_up_q     <= 1'b0;
      player_q      <= 1'b0;
      miss_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      mole_onehot_q <= mole_onehot_d;
      mole_idx_q    <= mole_idx_d;
      mole_up_q     <= mole_up_d;
      player_q      <= player_d;
      miss_q        <= miss_d;
    end
  end

  assign mole_onehot   = mole_onehot_q;
  assign mole_idx      = mole_idx_q;
  assign mole_up       = mole_up_q;
  assign player_signal = player_q;
  assign miss_signal   = miss_q;

endmodule

// File: tb/tb_mole_hit_detector.sv
// Directed bench for mole_hit_detector with short windows; mole index is predicted from a
// bench-side copy of the LFSR.
module tb_mole_hit_detector;

  logic       clk;
  logic       Resetn;
  logic       enable;
  logic [3:0] key_n;
  logic [3:0] mole_onehot;
  logic [1:0] mole_idx;
  logic       mole_up;
  logic       player_signal;
  logic       miss_signal;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_lfsr, m_prev;
  logic [1:0]  exp_idx;

  mole_hit_detector #(
    .NUM_HOLES    (4),
    .WINDOW_CYCLES(8),
    .GAP_CYCLES   (4),
    .DB_CYCLES    (2),
    .LFSR_SEED    (16'hACE1)
  ) dut (
    .clk          (clk),
    .Resetn       (Resetn),
    .enable       (enable),
    .key_n        (key_n),
    .mole_onehot  (mole_onehot),
    .mole_idx     (mole_idx),
    .mole_up      (mole_up),
    .player_signal(player_signal),
    .miss_signal  (miss_signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // m_prev holds the LFSR value the DUT saw just before the most recent edge.
  always @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called in the first UP cycle of every round.
  task automatic check_mole(input string tag);
    logic [1:0] cand;
    logic [1:0] nxt;
    logic [3:0] oh;
    cand = m_prev[1:0];
    nxt  = (cand == exp_idx) ? cand + 2'd1 : cand;
    oh   = 4'b0001 << nxt;
    check({tag, "_up"}, 32'(mole_up), 32'd1);
    check({tag, "_idx"}, 32'(mole_idx), 32'(nxt));
    check({tag, "_onehot"}, 32'(mole_onehot), 32'(oh));
    check({tag, "_differs"}, 32'(mole_idx != exp_idx), 32'd1);
    exp_idx = nxt;
  endtask

  initial begin
    logic [1:0] wrong;
    Resetn  = 1'b0;
    enable  = 1'b0;
    key_n   = 4'hF;
    exp_idx = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_onehot", 32'(mole_onehot), 32'd0);
    check("rst_idx", 32'(mole_idx), 32'd0);
    check("rst_up", 32'(mole_up), 32'd0);
    check("rst_player", 32'(player_signal), 32'd0);
    check("rst_miss", 32'(miss_signal), 32'd0);
    Resetn = 1'b1;
    step(2);
    check("idle_dark", 32'(mole_up), 32'd0);

    // Round 1: clean hit on the lit key.
    enable = 1'b1;
    step(4);
    check("gap_dark", 32'(mole_up), 32'd0);
    step(1);
    check_mole("r1");
    key_n = ~(4'b0001 << exp_idx);
    step(4);
    check("r1_no_early_hit", 32'(player_signal), 32'd0);
    step(1);
    check("r1_hit", 32'(player_signal), 32'd1);
    check("r1_hit_nomiss", 32'(miss_signal), 32'd0);
    check("r1_hit_off", 32'(mole_up), 32'd0);
    check("r1_hit_onehot", 32'(mole_onehot), 32'd0);
    key_n = 4'hF;
    step(1);
    check("r1_hit_width", 32'(player_signal), 32'd0);
    step(3);
    check_mole("r2");

    // Round 2: timeout.
    step(7);
    check("r2_last_up", 32'(mole_up), 32'd1);
    check("r2_no_early_miss", 32'(miss_signal), 32'd0);
    step(1);
    check("r2_timeout", 32'(miss_signal), 32'd1);
    check("r2_timeout_noplayer", 32'(player_signal), 32'd0);
    check("r2_timeout_off", 32'(mole_up), 32'd0);
    step(1);
    check("r2_miss_width", 32'(miss_signal), 32'd0);
    step(3);
    check_mole("r3");

    // Round 3: wrong key only.
    wrong = exp_idx + 2'd1;
    key_n = ~(4'b0001 << wrong);
    step(4);
    check("r3_no_early_miss", 32'(miss_signal), 32'd0);
    step(1);
    check("r3_wrong_miss", 32'(miss_signal), 32'd1);
    check("r3_wrong_noplayer", 32'(player_signal), 32'd0);
    check("r3_wrong_off", 32'(mole_up), 32'd0);
    key_n = 4'hF;
    step(1);
    check("r3_miss_width", 32'(miss_signal), 32'd0);
    step(3);
    check_mole("r4");

    // Round 4: wrong key and lit key in the same cycle.
    wrong = exp_idx + 2'd1;
    key_n = ~((4'b0001 << exp_idx) | (4'b0001 << wrong));
    step(4);
    check("r4_no_early", 32'(player_signal | miss_signal), 32'd0);
    step(1);
    check("r4_both_hit", 32'(player_signal), 32'd1);
    check("r4_both_nomiss", 32'(miss_signal), 32'd0);
    step(1);
    check("r4_after", 32'(player_signal | miss_signal), 32'd0);
    step(3);
    check_mole("r5");

    // Round 5: keys still held from round 4 give no new event.
    step(7);
    check("r5_held_noplayer", 32'(player_signal), 32'd0);
    check("r5_held_nomiss", 32'(miss_signal), 32'd0);
    step(1);
    check("r5_held_timeout", 32'(miss_signal), 32'd1);
    check("r5_held_noplayer2", 32'(player_signal), 32'd0);
    key_n = 4'hF;
    step(4);
    check_mole("r6");

    // Bounce all keys for 10 cycles, then hold: one event, landing in round 7.
    for (int i = 0; i < 10; i++) begin
      key_n = (i % 2 == 1) ? 4'hF : 4'h0;
      step(1);
      if (i == 7) begin
        check("r6_bounce_timeout", 32'(miss_signal), 32'd1);
        check("r6_bounce_noplayer", 32'(player_signal), 32'd0);
      end
    end
    key_n = 4'h0;
    step(2);
    check_mole("r7");
    step(2);
    check("r7_no_early", 32'(player_signal | miss_signal), 32'd0);
    step(1);
    check("r7_bounce_hit", 32'(player_signal), 32'd1);
    check("r7_bounce_nomiss", 32'(miss_signal), 32'd0);
    step(4);
    check_mole("r8");
    step(7);
    check("r8_held_none", 32'(player_signal | miss_signal), 32'd0);
    step(1);
    check("r8_held_timeout", 32'(miss_signal), 32'd1);
    check("r8_held_noplayer", 32'(player_signal), 32'd0);
    key_n = 4'hF;
    step(4);
    check_mole("r9");

    // Round 9: enable drops in the press-event cycle.
    key_n = ~(4'b0001 << exp_idx);
    step(4);
    check("r9_up_before_drop", 32'(mole_up), 32'd1);
    enable = 1'b0;
    step(1);
    check("r9_drop_noplayer", 32'(player_signal), 32'd0);
    check("r9_drop_nomiss", 32'(miss_signal), 32'd0);
    check("r9_drop_off", 32'(mole_up), 32'd0);
    check("r9_drop_onehot", 32'(mole_onehot), 32'd0);
    check("r9_drop_idx_kept", 32'(mole_idx), 32'(exp_idx));
    key_n = 4'hF;
    step(2);
    check("r9_idle_quiet", 32'(player_signal | miss_signal | mole_up), 32'd0);

    // Round 10: asynchronous reset while the mole is up.
    enable = 1'b1;
    step(5);
    check_mole("r10");
    step(2);
    Resetn = 1'b0;
    #1;
    check("ar_onehot", 32'(mole_onehot), 32'd0);
    check("ar_idx", 32'(mole_idx), 32'd0);
    check("ar_up", 32'(mole_up), 32'd0);
    check("ar_pulses", 32'(player_signal | miss_signal), 32'd0);
    step(1);
    enable = 1'b0;
    Resetn = 1'b1;
    exp_idx = 2'd0;
    step(2);
    check("ar_idle_onehot", 32'(mole_onehot), 32'd0);
    check("ar_idle_up", 32'(mole_up), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
